wdg_wb_initiator: RTL

- Wishbone pipelined-mode bus initiator that drives the watchdog register file (WDCSR/WDCNT) from a simple valid/ready command channel, e.g. a service sequencer or debug port.
- Issues one single-beat read or write per command.
- Handles stall, ack, err and rty, with a bounded retry count and a cycle timeout.
- Returns read data plus a status code on a valid/ready response channel.

---
 rtl/wdg_wb_initiator_pkg.sv | 23 ++
 rtl/wdg_wb_initiator_if.sv | 45 ++++
 rtl/wdg_wb_initiator_term_timer.sv | 29 ++
 rtl/wdg_wb_initiator.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/wdg_wb_initiator_pkg.sv
// Shared encodings for the watchdog Wishbone initiator: response status, FSM states
// and the symbolic register addresses used by command sequencers.
package wdg_wb_initiator_pkg;

   typedef enum logic [1:0] {
      ST_OK      = 2'b00,
      ST_ERR     = 2'b01,
      ST_TIMEOUT = 2'b10,
      ST_RTY_EXH = 2'b11
   } status_t;

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      WAIT,
      BACKOFF,
      RESP
   } state_t;

   localparam logic [1:0] ADR_WDCSR = 2'd0;
   localparam logic [1:0] ADR_WDCNT = 2'd1;

endpackage

// File: rtl/wdg_wb_initiator_if.sv
// Command, response and Wishbone signals of the watchdog initiator.
// master is the initiator's view, slave is the view of everything around it.
interface wdg_wb_initiator_if #(
   parameter int ADDRESS_WIDTH = 2,
   parameter int DATA_WIDTH    = 32
);
   localparam int SEL_WIDTH = DATA_WIDTH / 8;

   logic                     i_cmd_valid;
   logic                     o_cmd_ready;
   logic                     i_cmd_we;
   logic [ADDRESS_WIDTH-1:0] i_cmd_adr;
   logic [DATA_WIDTH-1:0]    i_cmd_dat;
   logic [SEL_WIDTH-1:0]     i_cmd_sel;
   logic                     o_rsp_valid;
   logic                     i_rsp_ready;
   logic [DATA_WIDTH-1:0]    o_rsp_dat;
   logic [1:0]               o_rsp_status;
   logic                     o_wb_cyc;
   logic                     o_wb_stb;
   logic                     i_wb_stall;
   logic [ADDRESS_WIDTH-1:0] o_wb_adr;
   logic                     o_wb_we;
   logic [DATA_WIDTH-1:0]    o_wb_dat;
   logic [SEL_WIDTH-1:0]     o_wb_sel;
   logic                     i_wb_ack;
   logic                     i_wb_err;
   logic                     i_wb_rty;
   logic [DATA_WIDTH-1:0]    i_wb_dat;

   modport master (
      input  i_cmd_valid, i_cmd_we, i_cmd_adr, i_cmd_dat, i_cmd_sel, i_rsp_ready,
      input  i_wb_stall, i_wb_ack, i_wb_err, i_wb_rty, i_wb_dat,
      output o_cmd_ready, o_rsp_valid, o_rsp_dat, o_rsp_status,
      output o_wb_cyc, o_wb_stb, o_wb_adr, o_wb_we, o_wb_dat, o_wb_sel
   );

   modport slave (
      output i_cmd_valid, i_cmd_we, i_cmd_adr, i_cmd_dat, i_cmd_sel, i_rsp_ready,
      output i_wb_stall, i_wb_ack, i_wb_err, i_wb_rty, i_wb_dat,
      input  o_cmd_ready, o_rsp_valid, o_rsp_dat, o_rsp_status,
      input  o_wb_cyc, o_wb_stb, o_wb_adr, o_wb_we, o_wb_dat, o_wb_sel
   );

endinterface

// File: rtl/wdg_wb_initiator_term_timer.sv
// wb_term_timer: per-attempt bus cycle counter; expired is high during the last
// allowed cycle of an attempt. Saturates instead of wrapping.
module wb_term_timer #(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic clk,
   input  logic res,
   input  logic clear,
   input  logic enable,
   output logic expired
);
   localparam int CW = $clog2(TIMEOUT_CYCLES);
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

   logic [CW-1:0] count;

   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable && count != LAST) begin
         count <= count + CW'(1);
      end
   end

   assign expired = (count == LAST);

endmodule

// File: rtl/wdg_wb_initiator.sv
// Single-beat Wishbone pipelined initiator for the watchdog register file, with
// retry on rty, per-attempt timeout and a registered valid/ready response channel.
module wdg_wb_initiator
   import wdg_wb_initiator_pkg::*;
#(
   parameter int ADDRESS_WIDTH  = 2,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 16,
   parameter int MAX_RETRIES    = 3
) (
   input logic                clk,
   input logic                res,
   wdg_wb_initiator_if.master bus
);
   localparam int SEL_WIDTH = DATA_WIDTH / 8;
   localparam int RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
   localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRIES);

   state_t                   state_q, state_d;
   status_t                  status_q, status_d;
   logic [RW-1:0]            retry_q, retry_d;
   logic                     cyc_q, cyc_d, stb_q, stb_d;
   logic                     ready_q, ready_d, rsp_valid_q, rsp_valid_d;
   logic                     we_q, we_d;
   logic [ADDRESS_WIDTH-1:0] adr_q, adr_d;
   logic [DATA_WIDTH-1:0]    dat_q, dat_d, rsp_dat_q, rsp_dat_d;
   logic [SEL_WIDTH-1:0]     sel_q, sel_d;
   logic                     timer_clear, timer_expired;

   wb_term_timer #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timer (
      .clk    (clk),
      .res    (res),
      .clear  (timer_clear),
      .enable ((state_q == REQ) || (state_q == WAIT)),
      .expired(timer_expired)
   );

   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         state_q     <= IDLE;
         status_q    <= ST_OK;
         retry_q     <= '0;
         cyc_q       <= 1'b0;
         stb_q       <= 1'b0;
         ready_q     <= 1'b0;
         rsp_valid_q <= 1'b0;
         we_q        <= 1'b0;
         adr_q       <= '0;
         dat_q       <= '0;
         sel_q       <= '0;
         rsp_dat_q   <= '0;
      end else begin
         state_q     <= state_d;
         status_q    <= status_d;
         retry_q     <= retry_d;
         cyc_q       <= cyc_d;
         stb_q       <= stb_d;
         ready_q     <= ready_d;
         rsp_valid_q <= rsp_valid_d;
         we_q        <= we_d;
         adr_q       <= adr_d;
         dat_q       <= dat_d;
         sel_q       <= sel_d;
         rsp_dat_q   <= rsp_dat_d;
      end
   end

   // Every output is computed one cycle ahead so the bus sees only flop outputs.
   always_comb begin
      state_d     = state_q;
      status_d    = status_q;
      retry_d     = retry_q;
      cyc_d       = cyc_q;
      stb_d       = stb_q;
      ready_d     = ready_q;
      rsp_valid_d = rsp_valid_q;
      we_d        = we_q;
      adr_d       = adr_q;
      dat_d       = dat_q;
      sel_d       = sel_q;
      rsp_dat_d   = rsp_dat_q;
      timer_clear = 1'b0;
      unique case (state_q)
         IDLE: begin
            ready_d = 1'b1;
            if (ready_q && bus.i_cmd_valid) begin
               we_d        = bus.i_cmd_we;
               adr_d       = bus.i_cmd_adr;
               dat_d       = bus.i_cmd_dat;
               sel_d       = bus.i_cmd_sel;
               retry_d     = '0;
               timer_clear = 1'b1;
               ready_d     = 1'b0;
               cyc_d       = 1'b1;
               stb_d       = 1'b1;
               state_d     = REQ;
            end
         end
         REQ: begin
            if (timer_expired) begin
               cyc_d       = 1'b0;
               stb_d       = 1'b0;
               rsp_valid_d = 1'b1;
               rsp_dat_d   = '0;
               status_d    = ST_TIMEOUT;
               state_d     = RESP;
            end else if (!bus.i_wb_stall) begin
               stb_d   = 1'b0;
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (bus.i_wb_err || bus.i_wb_rty || bus.i_wb_ack || timer_expired) begin
               cyc_d       = 1'b0;
               rsp_valid_d = 1'b1;
               rsp_dat_d   = '0;
               state_d     = RESP;
               if (bus.i_wb_err) begin
                  status_d = ST_ERR;
               end else if (bus.i_wb_rty) begin
                  if (retry_q < RETRY_LIMIT) begin
                     retry_d     = retry_q + RW'(1);
                     rsp_valid_d = 1'b0;
                     state_d     = BACKOFF;
                  end else begin
                     status_d = ST_RTY_EXH;
                  end
               end else if (bus.i_wb_ack) begin
                  status_d  = ST_OK;
                  rsp_dat_d = we_q ? '0 : bus.i_wb_dat;
               end else begin
                  status_d = ST_TIMEOUT;
               end
            end
         end
         BACKOFF: begin
            timer_clear = 1'b1;
            cyc_d       = 1'b1;
            stb_d       = 1'b1;
            state_d     = REQ;
         end
         RESP: begin
            if (bus.i_rsp_ready) begin
               rsp_valid_d = 1'b0;
               rsp_dat_d   = '0;
               status_d    = ST_OK;
               ready_d     = 1'b1;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.o_cmd_ready  = ready_q;
   assign bus.o_rsp_valid  = rsp_valid_q;
   assign bus.o_rsp_dat    = rsp_dat_q;
   assign bus.o_rsp_status = status_q;
   assign bus.o_wb_cyc     = cyc_q;
   assign bus.o_wb_stb     = stb_q;
   assign bus.o_wb_adr     = adr_q;
   assign bus.o_wb_we      = we_q;
   assign bus.o_wb_dat     = dat_q;
   assign bus.o_wb_sel     = sel_q;

endmodule
